imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the multi-cycle datapath. It generalises plain 16-to-32 sign extension.
- Accepts an IN_W-bit immediate plus a 2-bit mode and produces an OUT_W-bit extended value. Modes: sign, zero, upper-load, branch-offset.
- Input and output use valid/ready handshakes, with a 2-entry output buffer between them. Decode can run ahead of the ALU-operand stage without stalling.

Parameters:
- IN_W, 16, immediate input width in bits (>= 2).
- OUT_W, 32, extended output width in bits. Constraint: OUT_W >= IN_W + 2.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_imm/in_mode are valid this cycle.
- in_ready  output  1  unit can accept an input this cycle.
- in_imm  input  IN_W  raw immediate field.
- in_mode  input  2  00 sign, 01 zero, 10 upper, 11 branch.
- out_valid  output  1  out_data holds a valid result.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  OUT_W  extended immediate (head entry).
- out_mode  output  2  mode the head entry was produced with.
- xfer_cnt  output  CNT_W  number of completed output transfers.
- flush  input  1  synchronous discard of all buffered entries.

Behaviour:
- Reset (rst_n low, asynchronous): buffer emptied (count=0), out_valid=0, out_data=0, out_mode=0, xfer_cnt=0, in_ready=1 from first cycle after release.
- Input accept: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- Extension is computed combinationally from in_imm/in_mode and written into the buffer on accept. Inputs are never stored raw.
- Mode 00 (sign): bits [IN_W-1:0]=in_imm; bits [OUT_W-1:IN_W]=in_imm[IN_W-1].
- Mode 01 (zero): bits [IN_W-1:0]=in_imm; upper bits 0.
- Mode 10 (upper): in_imm placed in bits [OUT_W-1:OUT_W-IN_W]; lower OUT_W-IN_W bits 0.
- Mode 11 (branch): sign-extended value shifted left by 2. Bits [1:0]=0. Bits shifted beyond OUT_W-1 are discarded, with no overflow flag.
- Latency: an accepted input appears at out_data on the next cycle (1 cycle) if the buffer was empty.
- Buffer: 2-entry FIFO, count in {0,1,2}.
  - in_ready = (count < 2); this is a registered signal, not combinational on out_ready.
  - out_valid = (count > 0).
  - out_data/out_mode always reflect the oldest entry.
- Simultaneous accept and transfer:
  - count=1: count stays 1; the new entry becomes head on the next cycle.
  - count=2: no accept is possible (in_ready=0); transfer drops count to 1.
- Ordering: strictly FIFO; entries are never reordered or dropped except by flush.
- Stability: while out_valid=1 and out_ready=0, out_data/out_mode must hold stable.
- xfer_cnt: increments by 1 per output transfer, wraps from 2^CNT_W-1 to 0. Flush does not clear it.
- flush: at the rising edge where flush=1:
  - count becomes 0 and out_valid becomes 0 on the next cycle.
  - An input accepted in the same cycle is also discarded.
  - An output transfer in the same cycle still counts in xfer_cnt.
- Reset mid-operation: all buffered entries are lost immediately and outputs return to their reset values asynchronously.

Optional Feature:
- Macro: IMM_EXT_PARITY_EN.
- When defined:
  - Extra output port out_parity (1 bit) = XOR reduction of out_data. It is stored per entry and follows the head entry.
  - Reset value 0.
- When undefined: the port and its storage are absent; all other behaviour is identical.

Test Plan:
- Mode sweep, IN_W=16, OUT_W=32, out_ready=1:
  - 0x8000/00 -> 0xFFFF8000
  - 0x8000/01 -> 0x00008000
  - 0x1234/10 -> 0x12340000
  - 0xFFFF/11 -> 0xFFFFFFFC
  - 0x7FFF/11 -> 0x0001FFFC
  - Each result appears one cycle after its accept.
- Backpressure: out_ready=0, push 0x0001/00, 0x0002/00, 0x0003/00.
  - in_ready drops after the 2nd accept; the 3rd is held off.
  - Then out_ready=1: outputs 0x00000001, 0x00000002, 0x00000003 in order; xfer_cnt=3.
- Simultaneous push/pop at count=1, streamed for 10 cycles:
  - count stays 1, in_ready stays 1, no bubbles, 10 transfers in order.
- Flush with count=2 plus a same-cycle accept: out_valid=0 next cycle, no stale data emitted, xfer_cnt unchanged.
- Wrap: CNT_W=4, 17 transfers -> xfer_cnt=1. Async reset asserted mid-stream -> out_valid=0 and xfer_cnt=0 without waiting for a clock edge.
- With IMM_EXT_PARITY_EN defined: 0x0007/01 -> out_parity=1; 0x0003/01 -> out_parity=0.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (sign/zero/upper/branch) feeding a 2-entry output FIFO.
// Optional IMM_EXT_PARITY_EN adds a per-entry out_parity output (XOR of out_data).
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode,
`ifdef IMM_EXT_PARITY_EN
  output logic             out_parity,
`endif
  output logic [CNT_W-1:0] xfer_cnt,
  input  logic             flush
);

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext;
  logic             push;
  logic             pop;
  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic [OUT_W-1:0] head_data_reg, tail_data_reg;
  logic [1:0]       head_mode_reg, tail_mode_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic [CNT_W-1:0] xfer_cnt_reg;

  assign sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

  always_comb begin
    ext = sext;
    case (in_mode)
      2'b00: ext = sext;
      2'b01: ext = {{(OUT_W-IN_W){1'b0}}, in_imm};
      2'b10: ext = {in_imm, {(OUT_W-IN_W){1'b0}}};
      2'b11: ext = {sext[OUT_W-3:0], 2'b00};
      default: ext = sext;
    endcase
  end

  assign push = in_valid && in_ready_reg;
  assign pop  = out_valid_reg && out_ready;

  always_comb begin
    count_next = count_reg + {1'b0, push} - {1'b0, pop};
    if (flush)
      count_next = 2'd0;
  end

  // Head is always the oldest entry; the tail slot is only occupied when count is 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= 2'd0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      head_data_reg <= '0;
      head_mode_reg <= 2'b00;
      tail_data_reg <= '0;
      tail_mode_reg <= 2'b00;
      xfer_cnt_reg  <= '0;
    end else begin
      count_reg     <= count_next;
      in_ready_reg  <= (count_next < 2'd2);
      out_valid_reg <= (count_next != 2'd0);
      if (pop)
        xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
      if (pop && count_reg == 2'd2) begin
        head_data_reg <= tail_data_reg;
        head_mode_reg <= tail_mode_reg;
      end else if (push && (count_reg == 2'd0 || (count_reg == 2'd1 && pop))) begin
        head_data_reg <= ext;
        head_mode_reg <= in_mode;
      end
      if (push && count_reg == 2'd1 && !pop) begin
        tail_data_reg <= ext;
        tail_mode_reg <= in_mode;
      end
    end
  end

`ifdef IMM_EXT_PARITY_EN
  logic head_par_reg, tail_par_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_par_reg <= 1'b0;
      tail_par_reg <= 1'b0;
    end else begin
      if (pop && count_reg == 2'd2)
        head_par_reg <= tail_par_reg;
      else if (push && (count_reg == 2'd0 || (count_reg == 2'd1 && pop)))
        head_par_reg <= ^ext;
      if (push && count_reg == 2'd1 && !pop)
        tail_par_reg <= ^ext;
    end
  end

  assign out_parity = head_par_reg;
`endif

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = head_data_reg;
  assign out_mode  = head_mode_reg;
  assign xfer_cnt  = xfer_cnt_reg;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: driver queues expected results, a negedge monitor checks transfers.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  out_mode;
  logic [3:0]  xfer_cnt;
  logic        flush = 1'b0;
`ifdef IMM_EXT_PARITY_EN
  logic        out_parity;
`endif

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
`ifdef IMM_EXT_PARITY_EN
    .out_parity(out_parity),
`endif
    .xfer_cnt(xfer_cnt), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  mode;
    logic        par;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t       sbq[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [3:0] xfer_model = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else
      $display("ok   %s: %0h", name, act);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge with in_valid still high.
  task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [31:0] exp,
                      input bit lat, output int waited);
    exp_t e;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout: imm=%0h never accepted", imm);
        break;
      end
    end
    if (!flush) begin
      e.data = exp; e.mode = mode; e.par = ^exp; e.cyc = cyc; e.lat = lat;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    $display("send imm=%04h mode=%0d exp=%08h waited=%0d", imm, mode, exp, waited);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: compares every output transfer against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sbq.delete();
      xfer_model = '0;
    end else begin
      total++;
      if (xfer_cnt !== xfer_model) begin
        bad++;
        $display("FAIL xfer_cnt: got %0d expected %0d", xfer_cnt, xfer_model);
      end
      if (out_valid && out_ready) begin
        xfer_model = xfer_model + 4'd1;
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: got data=%08h with nothing expected", out_data);
        end else begin
          e = sbq.pop_front();
          if (out_data !== e.data || out_mode !== e.mode) begin
            bad++;
            $display("FAIL out_data: got %08h/%0d expected %08h/%0d", out_data, out_mode, e.data, e.mode);
          end else
            $display("xfer data=%08h mode=%0d", out_data, out_mode);
`ifdef IMM_EXT_PARITY_EN
          total++;
          if (out_parity !== e.par) begin
            bad++;
            $display("FAIL out_parity: got %0b expected %0b", out_parity, e.par);
          end
`endif
          if (e.lat) begin
            total++;
            if (cyc != e.cyc + 1) begin
              bad++;
              $display("FAIL latency: got %0d cycles expected 1", cyc - e.cyc);
            end
          end
        end
      end
      if (flush) sbq.delete();
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    logic [3:0] base;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_out_mode", {62'd0, out_mode}, 64'd0);
    chk("rst_xfer_cnt", {60'd0, xfer_cnt}, 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Mode sweep, one result per cycle.
    out_ready = 1'b1;
    send(16'h8000, 2'b00, 32'hFFFF8000, 1'b1, w);
    send(16'h8000, 2'b01, 32'h00008000, 1'b1, w);
    send(16'h1234, 2'b10, 32'h12340000, 1'b1, w);
    send(16'hFFFF, 2'b11, 32'hFFFFFFFC, 1'b1, w);
    send(16'h7FFF, 2'b11, 32'h0001FFFC, 1'b1, w);
`ifdef IMM_EXT_PARITY_EN
    send(16'h0007, 2'b01, 32'h00000007, 1'b1, w);
    send(16'h0003, 2'b01, 32'h00000003, 1'b1, w);
`endif
    idle(3);

    // Backpressure: third input must be held off until the consumer drains.
    base = xfer_cnt;
    out_ready = 1'b0;
    send(16'h0001, 2'b00, 32'h00000001, 1'b0, w);
    send(16'h0002, 2'b00, 32'h00000002, 1'b0, w);
    fork
      send(16'h0003, 2'b00, 32'h00000003, 1'b1, w);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
          chk("bp_head_stable", {32'd0, out_data}, 64'h1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(3);
    chk("bp_xfer_plus3", {60'd0, xfer_cnt}, {60'd0, base + 4'd3});

    // Streaming at count=1: every push coincides with a pop.
    out_ready = 1'b0;
    send(16'h00AA, 2'b00, 32'h000000AA, 1'b0, w);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(16'h0100 + 16'(i), 2'b00, 32'h00000100 + 32'(i), 1'b1, w);
      chk("stream_no_stall", 64'(w), 64'd0);
    end
    idle(3);

    // Flush at count=2 with in_valid asserted, then flush with a same-cycle accept.
    base = xfer_cnt;
    out_ready = 1'b0;
    send(16'h0011, 2'b01, 32'h00000011, 1'b0, w);
    send(16'h0022, 2'b01, 32'h00000022, 1'b0, w);
    flush = 1'b1;
    in_imm = 16'h0033;
    @(negedge clk);
    chk("flush_full_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    send(16'h0044, 2'b01, 32'h00000044, 1'b0, w);
    flush = 1'b1;
    send(16'h0055, 2'b01, 32'h00000055, 1'b0, w);
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_accept_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(4);
    chk("flush_xfer_same", {60'd0, xfer_cnt}, {60'd0, base});

    // Asynchronous reset mid-stream with data buffered and a nonzero counter.
    out_ready = 1'b0;
    send(16'h0066, 2'b00, 32'h00000066, 1'b0, w);
    send(16'h0077, 2'b00, 32'h00000077, 1'b0, w);
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_xfer_cnt", {60'd0, xfer_cnt}, 64'd0);
    chk("async_out_data", {32'd0, out_data}, 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("async_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // 17 transfers wrap the 4-bit counter to 1.
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++)
      send(16'hF000 + 16'(i), 2'b01, 32'h0000F000 + 32'(i), 1'b1, w);
    idle(3);
    chk("wrap_xfer_cnt", {60'd0, xfer_cnt}, 64'd1);
    chk("drained_out_valid", {63'd0, out_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
